mem_unit: RTL and testbench



---
 rtl/mem_unit_pkg.sv | 12 +
 rtl/mem_unit_if.sv | 31 +++
 rtl/mem_unit_loader.sv | 74 +++++++
 rtl/mem_unit.sv | 74 +++++++
 tb/tb_mem_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_unit_pkg.sv
// Shared widths, default sizes and loader state encoding for the unified memory.
package mem_unit_pkg;
  localparam int WORD_LEN      = 32;
  localparam int DEF_MEM_BYTES = 16384;
  localparam int DEF_LEN_W     = 16;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_DONE = 2'd2
  } ld_state_e;
endpackage

// File: rtl/mem_unit_if.sv
// Core fetch/load/store port plus byte-stream loader port of the unified memory.
interface mem_unit_if
  import mem_unit_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
);
  logic [WORD_LEN-1:0] addr_i;
  logic [WORD_LEN-1:0] inst;
  logic [WORD_LEN-1:0] addr_d;
  logic [WORD_LEN-1:0] rdata;
  logic                wen;
  logic [WORD_LEN-1:0] wdata;
  logic                ld_start;
  logic [LEN_W-1:0]    ld_len;
  logic                ld_valid;
  logic                ld_ready;
  logic [7:0]          ld_byte;
  logic                ld_done;
  logic                core_hold;
  logic                wr_conflict;

  modport master (
    output addr_i, addr_d, wen, wdata, ld_start, ld_len, ld_valid, ld_byte,
    input  inst, rdata, ld_ready, ld_done, core_hold, wr_conflict
  );

  modport slave (
    input  addr_i, addr_d, wen, wdata, ld_start, ld_len, ld_valid, ld_byte,
    output inst, rdata, ld_ready, ld_done, core_hold, wr_conflict
  );
endinterface

// File: rtl/mem_unit_loader.sv
// Byte-stream program loader: counts ld_len accepted bytes into storage from address 0,
// pulses ld_done once, and reports busy while active so the core can be held off.
module mem_loader
  import mem_unit_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int LEN_W     = DEF_LEN_W,
  localparam int AW       = $clog2(MEM_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_start,
  input  logic [LEN_W-1:0] ld_len,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [7:0]       ld_byte,
  output logic             ld_done,
  output logic             busy,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [7:0]       wbyte
);
  ld_state_e        state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= L_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      L_IDLE: begin
        if (ld_start) begin
          cnt_d   = ld_len;
          ptr_d   = '0;
          state_d = (ld_len == '0) ? L_DONE : L_LOAD;
        end
      end
      L_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = L_DONE;
        end
      end
      L_DONE: begin
        ld_done = 1'b1;
        state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  assign busy  = (state_q != L_IDLE);
  assign waddr = ptr_q;
  assign wbyte = ld_byte;
endmodule

// File: rtl/mem_unit.sv
// Unified little-endian byte memory: zero-latency word reads for fetch and data,
// clocked 32-bit stores, and a program loader that owns the write port while busy.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int LEN_W     = DEF_LEN_W,
  localparam int AW       = $clog2(MEM_BYTES)
) (
  input  logic     clk,
  input  logic     rst,
  mem_unit_if.slave bus
);
  logic [7:0]          mem [MEM_BYTES];
  logic [AW-1:0]       ai, ad;
  logic [WORD_LEN-1:0] inst_w, rdata_w;
  logic                ld_we, hold;
  logic [AW-1:0]       ld_addr;
  logic [7:0]          ld_wbyte;
  logic                wr_conflict_q, wr_conflict_d;
  logic                unused_addr_bits;

  assign ai = bus.addr_i[AW-1:0];
  assign ad = bus.addr_d[AW-1:0];
  assign unused_addr_bits = ^{bus.addr_i[WORD_LEN-1:AW], bus.addr_d[WORD_LEN-1:AW]};

  mem_loader #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (bus.ld_start),
    .ld_len   (bus.ld_len),
    .ld_valid (bus.ld_valid),
    .ld_ready (bus.ld_ready),
    .ld_byte  (bus.ld_byte),
    .ld_done  (bus.ld_done),
    .busy     (hold),
    .we       (ld_we),
    .waddr    (ld_addr),
    .wbyte    (ld_wbyte)
  );

  // Byte lanes wrap independently so misaligned words straddle the array end.
  always_comb begin
    inst_w  = '0;
    rdata_w = '0;
    for (int k = 0; k < 4; k++) begin
      inst_w[8*k +: 8]  = mem[ai + AW'(k)];
      rdata_w[8*k +: 8] = mem[ad + AW'(k)];
    end
  end

  // Loader writes only happen while hold is high, so it always beats a core store.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_wbyte;
    end else if (bus.wen && !hold) begin
      for (int k = 0; k < 4; k++) begin
        mem[ad + AW'(k)] <= bus.wdata[8*k +: 8];
      end
    end
  end

  assign wr_conflict_d = wr_conflict_q | (bus.wen & hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_conflict_q <= 1'b0;
    else     wr_conflict_q <= wr_conflict_d;
  end

  assign bus.inst        = inst_w;
  assign bus.rdata       = rdata_w;
  assign bus.core_hold   = hold;
  assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit: loader, stores, wrap, conflicts, reset abort.
module tb_mem_unit;
  import mem_unit_pkg::*;

  localparam int MB = DEF_MEM_BYTES;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_unit_if bus ();

  mem_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.addr_i   = '0;
    bus.addr_d   = '0;
    bus.wen      = 1'b0;
    bus.wdata    = '0;
    bus.ld_start = 1'b0;
    bus.ld_len   = '0;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got %b exp 0", bus.ld_ready); end
    checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL rst_ld_done got %b exp 0", bus.ld_done); end
    checks++; if (bus.core_hold !== 1'b0) begin errors++; $display("FAIL rst_core_hold got %b exp 0", bus.core_hold); end
    checks++; if (bus.wr_conflict !== 1'b0) begin errors++; $display("FAIL rst_wr_conflict got %b exp 0", bus.wr_conflict); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load8();
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
    bus.ld_start = 1'b1;
    bus.ld_len   = 16'd8;
    @(negedge clk);
    bus.ld_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL load8_ready[%0d] got %b exp 1", i, bus.ld_ready); end
      checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL load8_hold[%0d] got %b exp 1", i, bus.core_hold); end
      checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL load8_early_done[%0d] got %b exp 0", i, bus.ld_done); end
      bus.ld_valid = 1'b1;
      bus.ld_byte  = prog[i];
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL load8_done got %b exp 1", bus.ld_done); end
    checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL load8_done_hold got %b exp 1", bus.core_hold); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL load8_done_ready got %b exp 0", bus.ld_ready); end
    @(negedge clk);
    checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL load8_done_width got %b exp 0", bus.ld_done); end
    checks++; if (bus.core_hold !== 1'b0) begin errors++; $display("FAIL load8_hold_release got %b exp 0", bus.core_hold); end
    bus.addr_i = 32'h0; #1;
    checks++; if (bus.inst !== 32'h00100513) begin errors++; $display("FAIL load8_inst0 got %h exp 00100513", bus.inst); end
    bus.addr_i = 32'h4; #1;
    checks++; if (bus.inst !== 32'h00000073) begin errors++; $display("FAIL load8_inst4 got %h exp 00000073", bus.inst); end
  endtask

  task automatic test_store();
    @(negedge clk);
    bus.addr_d = 32'h100;
    bus.wdata  = 32'hDEADBEEF;
    bus.wen    = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0;
    #1;
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_aligned got %h exp deadbeef", bus.rdata); end
    bus.addr_d = 32'h101; #1;
    checks++; if (bus.rdata[23:0] !== 24'hDEADBE) begin errors++; $display("FAIL store_misaligned got %h exp deadbe", bus.rdata[23:0]); end
    checks++; if (bus.wr_conflict !== 1'b0) begin errors++; $display("FAIL store_no_conflict got %b exp 0", bus.wr_conflict); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.addr_d = 32'(MB - 2);
    bus.wdata  = 32'h11223344;
    bus.wen    = 1'b1;
    @(negedge clk);
    bus.wen    = 1'b0;
    bus.addr_d = 32'h0; #1;
    checks++; if (bus.rdata[15:0] !== 16'h1122) begin errors++; $display("FAIL wrap_low got %h exp 1122", bus.rdata[15:0]); end
    bus.addr_d = 32'(MB - 2); #1;
    checks++; if (bus.rdata[15:0] !== 16'h3344) begin errors++; $display("FAIL wrap_top got %h exp 3344", bus.rdata[15:0]); end
    // Address bits above the array size must alias onto the same storage.
    bus.addr_i = 32'(MB + 4); #1;
    checks++; if (bus.inst !== 32'h00000073) begin errors++; $display("FAIL wrap_alias got %h exp 00000073", bus.inst); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_len   = 16'd2;
    @(negedge clk);
    bus.ld_start = 1'b0;
    bus.addr_d   = 32'h100;
    bus.wdata    = 32'h0;
    bus.wen      = 1'b1;
    @(negedge clk);
    checks++; if (bus.wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_set got %b exp 1", bus.wr_conflict); end
    bus.addr_d   = 32'h0;
    bus.wdata    = 32'h55555555;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hAA;
    @(negedge clk);
    bus.wen      = 1'b0;
    bus.ld_byte  = 8'hBB;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL conflict_done got %b exp 1", bus.ld_done); end
    @(negedge clk);
    bus.addr_d = 32'h100; #1;
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_dropped got %h exp deadbeef", bus.rdata); end
    bus.addr_d = 32'h0; #1;
    checks++; if (bus.rdata !== 32'h0010BBAA) begin errors++; $display("FAIL conflict_loader_wins got %h exp 0010bbaa", bus.rdata); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky got %b exp 1", bus.wr_conflict); end
  endtask

  task automatic test_gaps();
    logic       vld [5];
    logic [7:0] dat [5];
    vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    dat = '{8'h21, 8'hE0, 8'h22, 8'hE1, 8'h23};
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_len   = 16'd3;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL gaps_early_done[%0d] got %b exp 0", i, bus.ld_done); end
      checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL gaps_ready[%0d] got %b exp 1", i, bus.ld_ready); end
      bus.ld_start = (i == 1);
      bus.ld_len   = (i == 1) ? 16'd5 : 16'd3;
      bus.ld_valid = vld[i];
      bus.ld_byte  = dat[i];
      @(negedge clk);
    end
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL gaps_done got %b exp 1", bus.ld_done); end
    @(negedge clk);
    checks++; if (bus.core_hold !== 1'b0) begin errors++; $display("FAIL gaps_hold_release got %b exp 0", bus.core_hold); end
    bus.addr_i = 32'h0; #1;
    checks++; if (bus.inst !== 32'h00232221) begin errors++; $display("FAIL gaps_inst0 got %h exp 00232221", bus.inst); end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_len   = 16'd0;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hCC;
    @(negedge clk);
    bus.ld_start = 1'b0;
    checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL len0_done got %b exp 1", bus.ld_done); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL len0_ready got %b exp 0", bus.ld_ready); end
    checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL len0_hold got %b exp 1", bus.core_hold); end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL len0_done_width got %b exp 0", bus.ld_done); end
    #1;
    checks++; if (bus.inst !== 32'h00232221) begin errors++; $display("FAIL len0_no_write got %h exp 00232221", bus.inst); end
  endtask

  task automatic test_rst_abort();
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_len   = 16'd4;
    @(negedge clk);
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'h31;
    @(negedge clk);
    bus.ld_byte  = 8'h32;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    checks++; if (bus.core_hold !== 1'b1) begin errors++; $display("FAIL abort_hold_pre got %b exp 1", bus.core_hold); end
    rst = 1'b1; #1;
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", bus.ld_ready); end
    checks++; if (bus.core_hold !== 1'b0) begin errors++; $display("FAIL abort_hold got %b exp 0", bus.core_hold); end
    checks++; if (bus.wr_conflict !== 1'b0) begin errors++; $display("FAIL abort_conflict_clear got %b exp 0", bus.wr_conflict); end
    checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", bus.ld_done); end
    @(negedge clk);
    rst = 1'b0;
    bus.addr_i = 32'h0; #1;
    checks++; if (bus.inst !== 32'h00233231) begin errors++; $display("FAIL abort_retained got %h exp 00233231", bus.inst); end
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_len   = 16'd1;
    @(negedge clk);
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'h41;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL restart_done got %b exp 1", bus.ld_done); end
    #1;
    checks++; if (bus.inst !== 32'h00233241) begin errors++; $display("FAIL restart_ptr0 got %h exp 00233241", bus.inst); end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_load8();
    test_store();
    test_wrap();
    test_conflict();
    test_gaps();
    test_len_zero();
    test_rst_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
